demux2_tuple_bit_bits2_stream: RTL and testbench

- Buffered 1-to-2 demultiplexer for a Tuple(Bit, Bits(W1)) payload stream; the inverse-direction counterpart of the 2:1 tuple mux.
- One valid/ready input stream is steered by select S into one of two output lanes.
- Each lane owns a DEPTH-entry FIFO, so one lane back-pressuring never corrupts or drops the other lane's traffic.
- Sits between a shared producer and two independent consumers.

---
 rtl/demux2_tuple_bit_bits2_stream_if.sv | 45 ++++
 rtl/demux2_tuple_bit_bits2_stream.sv | 133 +++++++++++++
 tb/tb_demux2_tuple_bit_bits2_stream.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/demux2_tuple_bit_bits2_stream_if.sv
// Stream bundle for the buffered 1:2 tuple demux: one producer-side input
// stream with lane select, and two consumer-side output lanes with occupancy.
interface demux2_tuple_bit_bits2_stream_if #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W1    = 2
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // producer side
    logic          I__0;
    logic [W1-1:0] I__1;
    logic          S;
    logic          I_valid;
    logic          I_ready;

    // lane 0
    logic          O0__0;
    logic [W1-1:0] O0__1;
    logic          O0_valid;
    logic          O0_ready;
    logic [CW-1:0] O0_count;

    // lane 1
    logic          O1__0;
    logic [W1-1:0] O1__1;
    logic          O1_valid;
    logic          O1_ready;
    logic [CW-1:0] O1_count;

    // demux side
    modport slave (
        input  I__0, I__1, S, I_valid, O0_ready, O1_ready,
        output I_ready,
        output O0__0, O0__1, O0_valid, O0_count,
        output O1__0, O1__1, O1_valid, O1_count
    );

    // producer/consumer side
    modport master (
        output I__0, I__1, S, I_valid, O0_ready, O1_ready,
        input  I_ready,
        input  O0__0, O0__1, O0_valid, O0_count,
        input  O1__0, O1__1, O1_valid, O1_count
    );
endinterface

// File: rtl/demux2_tuple_bit_bits2_stream.sv
// Buffered 1:2 demultiplexer for a Tuple(Bit, Bits(W1)) stream. The input beat
// is steered by S into one of two lane FIFOs of DEPTH entries each, so a stalled
// lane never blocks or corrupts the other. Input ready depends only on the
// selected lane's registered occupancy (no pass-through when full).
module demux2_tuple_bit_bits2_stream #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W1    = 2
) (
    input  logic                              CLK,
    input  logic                              ASYNCRESET,
    demux2_tuple_bit_bits2_stream_if.slave    bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned DW = W1 + 1;

    // storage: entry = {field1, field0}
    logic [DW-1:0] mem_q  [2][DEPTH];
    logic [PW-1:0] rptr_q [2];
    logic [PW-1:0] rptr_d [2];
    logic [PW-1:0] wptr_q [2];
    logic [PW-1:0] wptr_d [2];
    logic [CW-1:0] cnt_q  [2];
    logic [CW-1:0] cnt_d  [2];
    logic [DW-1:0] last_q [2];
    logic [DW-1:0] last_d [2];

    logic [DW-1:0] head   [2];
    logic [DW-1:0] data_o [2];
    logic [1:0]    full;
    logic [1:0]    vld;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    rdy;
    logic          accept;
    logic [DW-1:0] wdata;

    // handshake decode: ready from registered fullness of the selected lane
    always_comb begin
        rdy    = {bus.O1_ready, bus.O0_ready};
        wdata  = {bus.I__1, bus.I__0};
        full   = '0;
        vld    = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            full[k] = (cnt_q[k] == CW'(DEPTH));
            vld[k]  = (cnt_q[k] != '0);
            head[k] = mem_q[k][rptr_q[k]];
        end
        accept  = bus.I_valid & ~full[bus.S];
        push[0] = accept & ~bus.S;
        push[1] = accept &  bus.S;
        pop     = vld & rdy;
    end

    // next-state for pointers, occupancy and the last-read holding register
    always_comb begin
        for (int unsigned k = 0; k < 2; k++) begin
            rptr_d[k] = rptr_q[k];
            wptr_d[k] = wptr_q[k];
            cnt_d[k]  = cnt_q[k];
            last_d[k] = last_q[k];
            if (pop[k]) begin
                rptr_d[k] = rptr_q[k] + PW'(1);
                last_d[k] = head[k];
            end
            if (push[k]) begin
                wptr_d[k] = wptr_q[k] + PW'(1);
            end
            unique case ({push[k], pop[k]})
                2'b10:   cnt_d[k] = cnt_q[k] + CW'(1);
                2'b01:   cnt_d[k] = cnt_q[k] - CW'(1);
                default: cnt_d[k] = cnt_q[k];
            endcase
        end
    end

    // register pointers, counts and last-read value
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            for (int unsigned k = 0; k < 2; k++) begin
                rptr_q[k] <= '0;
                wptr_q[k] <= '0;
                cnt_q[k]  <= '0;
                last_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 2; k++) begin
                rptr_q[k] <= rptr_d[k];
                wptr_q[k] <= wptr_d[k];
                cnt_q[k]  <= cnt_d[k];
                last_q[k] <= last_d[k];
            end
        end
    end

    // lane storage write; reset clears all entries
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            for (int unsigned k = 0; k < 2; k++) begin
                for (int unsigned e = 0; e < DEPTH; e++) begin
                    mem_q[k][e] <= '0;
                end
            end
        end else begin
            for (int unsigned k = 0; k < 2; k++) begin
                if (push[k]) begin
                    mem_q[k][wptr_q[k]] <= wdata;
                end
            end
        end
    end

    // Head slot is not rewritten after a pop until it has been refilled, but
    // the empty-lane outputs must show the entry actually read last, so an
    // empty lane presents the holding register instead of the stale slot.
    always_comb begin
        for (int unsigned k = 0; k < 2; k++) begin
            data_o[k] = vld[k] ? head[k] : last_q[k];
        end
    end

    assign bus.I_ready  = ~full[bus.S];

    assign bus.O0__0    = data_o[0][0];
    assign bus.O0__1    = data_o[0][DW-1:1];
    assign bus.O0_valid = vld[0];
    assign bus.O0_count = cnt_q[0];

    assign bus.O1__0    = data_o[1][0];
    assign bus.O1__1    = data_o[1][DW-1:1];
    assign bus.O1_valid = vld[1];
    assign bus.O1_count = cnt_q[1];
endmodule

// File: tb/tb_demux2_tuple_bit_bits2_stream.sv
// Bench for the buffered 1:2 tuple demux: queue-based lane model compared on
// every falling edge, plus directed literal checks of the key scenarios.
module tb_demux2_tuple_bit_bits2_stream;
    localparam int DEPTH = 2;
    localparam int W1    = 2;

    logic CLK = 1'b0;
    logic rst = 1'b1;

    demux2_tuple_bit_bits2_stream_if #(.DEPTH(DEPTH), .W1(W1)) bus ();

    demux2_tuple_bit_bits2_stream #(.DEPTH(DEPTH), .W1(W1)) dut (
        .CLK        (CLK),
        .ASYNCRESET (rst),
        .bus        (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // reference model: one queue of {field1, field0} per lane
    logic [2:0] q0[$];
    logic [2:0] q1[$];
    logic [2:0] last0 = '0;
    logic [2:0] last1 = '0;

    always @(negedge CLK) begin
        logic [2:0] e0, e1;
        logic       p0, p1, ps;
        int         ssize;
        if (rst) begin
            q0.delete();
            q1.delete();
            last0 = '0;
            last1 = '0;
        end
        e0 = (q0.size() > 0) ? q0[0] : last0;
        e1 = (q1.size() > 0) ? q1[0] : last1;
        ssize = bus.S ? q1.size() : q0.size();
        check("m_I_ready",  int'(bus.I_ready),  int'(ssize < DEPTH));
        check("m_O0_valid", int'(bus.O0_valid), int'(q0.size() > 0));
        check("m_O1_valid", int'(bus.O1_valid), int'(q1.size() > 0));
        check("m_O0_count", int'(bus.O0_count), q0.size());
        check("m_O1_count", int'(bus.O1_count), q1.size());
        check("m_O0_data",  int'({bus.O0__1, bus.O0__0}), int'(e0));
        check("m_O1_data",  int'({bus.O1__1, bus.O1__0}), int'(e1));
        if (!rst) begin
            p0 = (q0.size() > 0) && bus.O0_ready;
            p1 = (q1.size() > 0) && bus.O1_ready;
            ps = bus.I_valid && (ssize < DEPTH);
            if (p0) last0 = q0.pop_front();
            if (p1) last1 = q1.pop_front();
            if (ps) begin
                if (bus.S) q1.push_back({bus.I__1, bus.I__0});
                else       q0.push_back({bus.I__1, bus.I__0});
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [2:0] d);
        bus.I_valid = v;
        bus.S       = s;
        bus.I__0    = d[0];
        bus.I__1    = d[2:1];
    endtask

    initial begin
        logic [2:0] v;
        drive(1'b0, 1'b0, 3'd0);
        bus.O0_ready = 1'b0;
        bus.O1_ready = 1'b0;

        // reset state with no clock edge yet
        #2;
        check("rst_O0_valid", int'(bus.O0_valid), 0);
        check("rst_O1_valid", int'(bus.O1_valid), 0);
        check("rst_O0_count", int'(bus.O0_count), 0);
        check("rst_O1_count", int'(bus.O1_count), 0);
        check("rst_I_ready",  int'(bus.I_ready), 1);
        check("rst_data",     int'({bus.O1__1, bus.O1__0, bus.O0__1, bus.O0__0}), 0);
        step();
        step();
        rst = 1'b0;
        step();

        // single routing to lane 1
        drive(1'b1, 1'b1, {2'b10, 1'b1});
        step();
        drive(1'b0, 1'b0, 3'd0);
        check("route_O1_valid", int'(bus.O1_valid), 1);
        check("route_O1__0",    int'(bus.O1__0), 1);
        check("route_O1__1",    int'(bus.O1__1), 2);
        check("route_O1_count", int'(bus.O1_count), 1);
        check("route_O0_valid", int'(bus.O0_valid), 0);
        bus.O1_ready = 1'b1;
        step();
        bus.O1_ready = 1'b0;
        check("hold_O1_valid", int'(bus.O1_valid), 0);
        check("hold_O1__1",    int'(bus.O1__1), 2);
        check("hold_O1__0",    int'(bus.O1__0), 1);

        // fill lane 0 and observe back-pressure
        drive(1'b1, 1'b0, 3'b011);
        step();
        drive(1'b1, 1'b0, 3'b110);
        step();
        drive(1'b1, 1'b0, 3'b101);
        #1;
        check("fill_O0_count", int'(bus.O0_count), 2);
        check("fill_I_ready0", int'(bus.I_ready), 0);
        check("fill_head",     int'({bus.O0__1, bus.O0__0}), 3);
        bus.S = 1'b1;
        #1;
        check("fill_I_ready1", int'(bus.I_ready), 1);
        bus.I_valid = 1'b0;

        // full lane popped: no same-cycle accept
        step();
        drive(1'b1, 1'b0, 3'b010);
        bus.O0_ready = 1'b1;
        #1;
        check("fpop_I_ready", int'(bus.I_ready), 0);
        step();
        check("fpop_count1", int'(bus.O0_count), 1);
        check("fpop_head",   int'({bus.O0__1, bus.O0__0}), 6);
        check("fpop_ready1", int'(bus.I_ready), 1);
        bus.O0_ready = 1'b0;
        step();
        bus.I_valid = 1'b0;
        check("fpop_count2", int'(bus.O0_count), 2);
        bus.O0_ready = 1'b1;
        repeat (3) step();
        bus.O0_ready = 1'b0;
        check("drain_count", int'(bus.O0_count), 0);
        check("drain_last",  int'({bus.O0__1, bus.O0__0}), 2);

        // streaming with alternating lanes
        bus.O0_ready = 1'b1;
        bus.O1_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            v = 3'(i % 8);
            drive(1'b1, 1'(i % 2), v);
            step();
            if (i % 2 == 0) begin
                check("stream_cnt0",  int'(bus.O0_count), 1);
                check("stream_head0", int'({bus.O0__1, bus.O0__0}), int'(v));
            end else begin
                check("stream_cnt1",  int'(bus.O1_count), 1);
                check("stream_head1", int'({bus.O1__1, bus.O1__0}), int'(v));
            end
        end
        bus.I_valid = 1'b0;
        step();

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom));
            bus.O0_ready = ($urandom_range(0, 3) != 0);
            bus.O1_ready = ($urandom_range(0, 2) == 0);
            step();
        end
        bus.I_valid  = 1'b0;
        bus.O0_ready = 1'b1;
        bus.O1_ready = 1'b1;
        repeat (4) step();
        bus.O0_ready = 1'b0;
        bus.O1_ready = 1'b0;

        // reset with both lanes full
        drive(1'b1, 1'b0, 3'b001); step();
        drive(1'b1, 1'b0, 3'b010); step();
        drive(1'b1, 1'b1, 3'b011); step();
        drive(1'b1, 1'b1, 3'b100); step();
        bus.I_valid = 1'b0;
        check("pre_rst_cnt0", int'(bus.O0_count), 2);
        check("pre_rst_cnt1", int'(bus.O1_count), 2);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", int'({bus.O1_valid, bus.O0_valid}), 0);
        check("mid_rst_count", int'({bus.O1_count, bus.O0_count}), 0);
        check("mid_rst_data",  int'({bus.O1__1, bus.O1__0, bus.O0__1, bus.O0__0}), 0);
        check("mid_rst_ready", int'(bus.I_ready), 1);
        step();
        step();
        rst = 1'b0;
        drive(1'b1, 1'b0, 3'b101);
        step();
        bus.I_valid = 1'b0;
        check("post_rst_cnt0", int'(bus.O0_count), 1);
        check("post_rst_head", int'({bus.O0__1, bus.O0__0}), 5);
        check("post_rst_v1",   int'(bus.O1_valid), 0);
        bus.O0_ready = 1'b1;
        step();
        check("post_rst_empty", int'(bus.O0_valid), 0);
        bus.O0_ready = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
